// File: rtl/npu_pool_pkg.sv
// Shared types and constants for the NPU pooling job sequencer.
package npu_pool_pkg;

    localparam int POOL_DIM_W   = 8;
    localparam int POOL_ADDR_W  = 16;
    localparam int K_ENC_OFFSET = 1;
    localparam int S_ENC_OFFSET = 1;

    typedef enum logic [1:0] {
        MAX    = 2'b00,
        AVG    = 2'b01,
        GLOBAL = 2'b10,
        RSVD   = 2'b11
    } pool_type_e;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        RUN,
        DONE
    } pool_seq_state_e;

    typedef struct packed {
        pool_type_e               ptype;
        logic [2:0]               kernel;
        logic [2:0]               stride;
        logic [2:0]               pad;
        logic [POOL_DIM_W-1:0]    height;
        logic [POOL_DIM_W-1:0]    width;
        logic [POOL_ADDR_W-1:0]   base;
    } pool_cfg_t;

    // Kernel and stride fields carry "value minus offset".
    function automatic logic [POOL_DIM_W-1:0] dec_field(input logic [2:0] f, input int off);
        return POOL_DIM_W'(f) + POOL_DIM_W'(off);
    endfunction

endpackage

// File: rtl/npu_pool_addr_gen.sv
// Element address / padding-flag generator with one output register stage.
module npu_pool_addr_gen #(
    parameter int DIM_W  = 8,
    parameter int ADDR_W = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    vld_i,
    input  logic signed [DIM_W+1:0] r0_i,
    input  logic signed [DIM_W+1:0] c0_i,
    input  logic [DIM_W-1:0]        kr_i,
    input  logic [DIM_W-1:0]        kc_i,
    input  logic [DIM_W-1:0]        height_i,
    input  logic [DIM_W-1:0]        width_i,
    input  logic [ADDR_W-1:0]       base_i,
    output logic                    pad_o,
    output logic [ADDR_W-1:0]       addr_o
);

    logic signed [DIM_W+2:0] r;
    logic signed [DIM_W+2:0] c;
    logic                    pad;
    logic [2*DIM_W-1:0]      prod;
    logic [ADDR_W-1:0]       addr;

    assign r = $signed({r0_i[DIM_W+1], r0_i}) + $signed({3'b000, kr_i});
    assign c = $signed({c0_i[DIM_W+1], c0_i}) + $signed({3'b000, kc_i});

    assign pad = r[DIM_W+2] || c[DIM_W+2]
              || (r >= $signed({3'b000, height_i}))
              || (c >= $signed({3'b000, width_i}));

    // Only meaningful when not padding, so the low bits are the true coordinates.
    assign prod = {{DIM_W{1'b0}}, r[DIM_W-1:0]} * {{DIM_W{1'b0}}, width_i};
    assign addr = base_i + ADDR_W'(prod) + ADDR_W'(c[DIM_W-1:0]);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pad_o  <= 1'b0;
            addr_o <= '0;
        end else begin
            pad_o  <= vld_i && pad;
            addr_o <= (vld_i && !pad) ? addr : '0;
        end
    end

endmodule

// File: rtl/npu_pool_seq.sv
// Pooling job sequencer: walks output windows and kernel elements, one request per handshake.
// Optional stall counter output enabled by defining NPU_POOL_SEQ_PERF_EN.
module npu_pool_seq
    import npu_pool_pkg::*;
#(
    parameter int DIM_W  = POOL_DIM_W,
    parameter int ADDR_W = POOL_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cfg_valid_i,
    output logic              cfg_ready_o,
    input  logic [1:0]        cfg_type_i,
    input  logic [2:0]        cfg_kernel_i,
    input  logic [2:0]        cfg_stride_i,
    input  logic [2:0]        cfg_pad_i,
    input  logic [DIM_W-1:0]  cfg_height_i,
    input  logic [DIM_W-1:0]  cfg_width_i,
    input  logic [ADDR_W-1:0] cfg_base_i,
    output logic              elem_valid_o,
    input  logic              elem_ready_i,
    output logic [ADDR_W-1:0] elem_addr_o,
    output logic              elem_pad_o,
    output logic              elem_first_o,
    output logic              elem_last_o,
    output logic [DIM_W-1:0]  out_row_o,
    output logic [DIM_W-1:0]  out_col_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
`ifdef NPU_POOL_SEQ_PERF_EN
    ,
    output logic [31:0]       stall_cnt_o
`endif
);

    localparam int CW = DIM_W + 2;
    localparam int XW = DIM_W + 4;

    function automatic logic signed [XW-1:0] ux(input logic [DIM_W-1:0] v);
        return $signed({4'b0000, v});
    endfunction

    function automatic logic signed [XW-1:0] sx(input logic signed [CW-1:0] v);
        return $signed({{2{v[CW-1]}}, v});
    endfunction

    pool_seq_state_e      state_q, state_d;
    pool_cfg_t            cfg_q, cfg_d;
    logic signed [CW-1:0] r0_q, r0_d, c0_q, c0_d;
    logic [DIM_W-1:0]     kr_q, kr_d, kc_q, kc_d, orow_q, orow_d, ocol_q, ocol_d;
    logic                 cfg_ready_q, busy_q, done_q, err_q, elem_valid_q;
    logic                 first_q, last_q, err_set;
    logic [DIM_W-1:0]     out_row_q, out_col_q;

    logic                 is_glob, accept, hs, reject, col_wrap, row_end, run_d;
    logic [DIM_W-1:0]     k_dim, kh, kw, s_dim, p_dim;
    logic signed [CW-1:0] neg_p;

    // Global pooling collapses to a single H x W window with unit stride and no padding.
    assign is_glob = (cfg_q.ptype == GLOBAL);
    assign k_dim   = dec_field(cfg_q.kernel, K_ENC_OFFSET);
    assign kh      = is_glob ? cfg_q.height : k_dim;
    assign kw      = is_glob ? cfg_q.width  : k_dim;
    assign s_dim   = is_glob ? DIM_W'(1) : dec_field(cfg_q.stride, S_ENC_OFFSET);
    assign p_dim   = is_glob ? '0 : DIM_W'(cfg_q.pad);
    assign neg_p   = -$signed({2'b00, p_dim});

    assign accept   = (state_q == IDLE) && cfg_valid_i && cfg_ready_q;
    assign hs       = elem_valid_q && elem_ready_i;
    assign reject   = (cfg_q.ptype == RSVD)
                   || (!is_glob && ((ux(k_dim) > ux(cfg_q.height) + ux(p_dim) + ux(p_dim))
                                 || (ux(k_dim) > ux(cfg_q.width)  + ux(p_dim) + ux(p_dim))));
    assign col_wrap = (sx(c0_q) + ux(s_dim) + ux(kw)) > (ux(cfg_q.width)  + ux(p_dim));
    assign row_end  = (sx(r0_q) + ux(s_dim) + ux(kh)) > (ux(cfg_q.height) + ux(p_dim));
    assign run_d    = (state_d == RUN);

    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        r0_d    = r0_q;
        c0_d    = c0_q;
        kr_d    = kr_q;
        kc_d    = kc_q;
        orow_d  = orow_q;
        ocol_d  = ocol_q;
        err_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cfg_d = '{ptype: pool_type_e'(cfg_type_i), kernel: cfg_kernel_i,
                              stride: cfg_stride_i, pad: cfg_pad_i, height: cfg_height_i,
                              width: cfg_width_i, base: cfg_base_i};
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (reject) begin
                    err_set = 1'b1;
                    state_d = DONE;
                end else begin
                    r0_d    = neg_p;
                    c0_d    = neg_p;
                    kr_d    = '0;
                    kc_d    = '0;
                    orow_d  = '0;
                    ocol_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Carry chain: kc -> kr -> output column -> output row.
                if (hs) begin
                    if (kc_q != kw - DIM_W'(1)) begin
                        kc_d = kc_q + DIM_W'(1);
                    end else begin
                        kc_d = '0;
                        if (kr_q != kh - DIM_W'(1)) begin
                            kr_d = kr_q + DIM_W'(1);
                        end else begin
                            kr_d = '0;
                            if (!col_wrap) begin
                                c0_d   = c0_q + $signed({2'b00, s_dim});
                                ocol_d = ocol_q + DIM_W'(1);
                            end else begin
                                c0_d   = neg_p;
                                ocol_d = '0;
                                if (!row_end) begin
                                    r0_d   = r0_q + $signed({2'b00, s_dim});
                                    orow_d = orow_q + DIM_W'(1);
                                end else begin
                                    state_d = DONE;
                                end
                            end
                        end
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            cfg_q        <= '0;
            r0_q         <= '0;
            c0_q         <= '0;
            kr_q         <= '0;
            kc_q         <= '0;
            orow_q       <= '0;
            ocol_q       <= '0;
            cfg_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            elem_valid_q <= 1'b0;
            first_q      <= 1'b0;
            last_q       <= 1'b0;
            out_row_q    <= '0;
            out_col_q    <= '0;
        end else begin
            state_q      <= state_d;
            cfg_q        <= cfg_d;
            r0_q         <= r0_d;
            c0_q         <= c0_d;
            kr_q         <= kr_d;
            kc_q         <= kc_d;
            orow_q       <= orow_d;
            ocol_q       <= ocol_d;
            cfg_ready_q  <= (state_d == IDLE);
            busy_q       <= (state_d != IDLE);
            done_q       <= (state_d == DONE);
            err_q        <= err_set;
            elem_valid_q <= run_d;
            first_q      <= run_d && (kr_d == '0) && (kc_d == '0);
            last_q       <= run_d && (kr_d == kh - DIM_W'(1)) && (kc_d == kw - DIM_W'(1));
            out_row_q    <= orow_d;
            out_col_q    <= ocol_d;
        end
    end

    // Fed from next-state counters so the registered address lines up with the markers.
    npu_pool_addr_gen #(
        .DIM_W  (DIM_W),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .vld_i    (run_d),
        .r0_i     (r0_d),
        .c0_i     (c0_d),
        .kr_i     (kr_d),
        .kc_i     (kc_d),
        .height_i (cfg_q.height),
        .width_i  (cfg_q.width),
        .base_i   (cfg_q.base),
        .pad_o    (elem_pad_o),
        .addr_o   (elem_addr_o)
    );

    assign cfg_ready_o  = cfg_ready_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign elem_valid_o = elem_valid_q;
    assign elem_first_o = first_q;
    assign elem_last_o  = last_q;
    assign out_row_o    = out_row_q;
    assign out_col_o    = out_col_q;

`ifdef NPU_POOL_SEQ_PERF_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else if (accept) begin
            stall_cnt_q <= '0;
        end else if (elem_valid_q && !elem_ready_i && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_npu_pool_seq.sv
// Scoreboard bench for npu_pool_seq: expected elements are queued at job issue, a monitor pops on handshake.
module tb_npu_pool_seq;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        cfg_valid_i;
    logic        cfg_ready_o;
    logic [1:0]  cfg_type_i;
    logic [2:0]  cfg_kernel_i, cfg_stride_i, cfg_pad_i;
    logic [7:0]  cfg_height_i, cfg_width_i;
    logic [15:0] cfg_base_i;
    logic        elem_valid_o, elem_ready_i;
    logic [15:0] elem_addr_o;
    logic        elem_pad_o, elem_first_o, elem_last_o;
    logic [7:0]  out_row_o, out_col_o;
    logic        busy_o, done_o, err_o;
`ifdef NPU_POOL_SEQ_PERF_EN
    logic [31:0] stall_cnt_o;
`endif

    always #5 clk = ~clk;

    npu_pool_seq dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .cfg_valid_i  (cfg_valid_i),
        .cfg_ready_o  (cfg_ready_o),
        .cfg_type_i   (cfg_type_i),
        .cfg_kernel_i (cfg_kernel_i),
        .cfg_stride_i (cfg_stride_i),
        .cfg_pad_i    (cfg_pad_i),
        .cfg_height_i (cfg_height_i),
        .cfg_width_i  (cfg_width_i),
        .cfg_base_i   (cfg_base_i),
        .elem_valid_o (elem_valid_o),
        .elem_ready_i (elem_ready_i),
        .elem_addr_o  (elem_addr_o),
        .elem_pad_o   (elem_pad_o),
        .elem_first_o (elem_first_o),
        .elem_last_o  (elem_last_o),
        .out_row_o    (out_row_o),
        .out_col_o    (out_col_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
`ifdef NPU_POOL_SEQ_PERF_EN
        ,
        .stall_cnt_o  (stall_cnt_o)
`endif
    );

    typedef struct {
        logic [15:0] addr;
        logic        pad;
        logic        first;
        logic        last;
        logic [7:0]  row;
        logic [7:0]  col;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          last_hs_cyc = 0;
    int          job_hs = 0;
    int          stalls = 0;
    bit          valid_seen = 0;
    bit          rand_rdy = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push_e(input logic [15:0] a, input logic p, input logic f, input logic l,
                          input logic [7:0] r, input logic [7:0] c);
        exp_t e;
        e.addr = a; e.pad = p; e.first = f; e.last = l; e.row = r; e.col = c;
        exp_q.push_back(e);
    endtask

    // Window enumeration from the geometric definition of pooling.
    task automatic push_model(input int h, input int w, input int k, input int s, input int p,
                              input int base, input bit glob);
        int kh, kw, ss, pp, orow, ocol, r, c;
        bit pd;
        kh = glob ? h : k; kw = glob ? w : k; ss = glob ? 1 : s; pp = glob ? 0 : p;
        orow = 0;
        for (int r0 = -pp; r0 + kh <= h + pp; r0 += ss) begin
            ocol = 0;
            for (int c0 = -pp; c0 + kw <= w + pp; c0 += ss) begin
                for (int kr = 0; kr < kh; kr++) begin
                    for (int kc = 0; kc < kw; kc++) begin
                        r  = r0 + kr;
                        c  = c0 + kc;
                        pd = (r < 0) || (r >= h) || (c < 0) || (c >= w);
                        push_e(pd ? 16'h0 : 16'(base + r * w + c), pd, (kr == 0) && (kc == 0),
                               (kr == kh - 1) && (kc == kw - 1), 8'(orow), 8'(ocol));
                    end
                end
                ocol++;
            end
            orow++;
        end
    endtask

    // 4x4 map, 2x2 kernel, stride 2, base 0x100.
    task automatic push_job1();
        logic [15:0] tbl [16];
        tbl = '{16'h100, 16'h101, 16'h104, 16'h105, 16'h102, 16'h103, 16'h106, 16'h107,
                16'h108, 16'h109, 16'h10C, 16'h10D, 16'h10A, 16'h10B, 16'h10E, 16'h10F};
        for (int i = 0; i < 16; i++)
            push_e(tbl[i], 1'b0, (i % 4) == 0, (i % 4) == 3, 8'((i / 4) / 2), 8'((i / 4) % 2));
    endtask

    task automatic start_job(input logic [1:0] t, input int k, input int s, input int p,
                             input int h, input int w, input logic [15:0] base, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!cfg_ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_cfg_ready"}, 64'(cfg_ready_o), 64'd1);
        cfg_type_i = t; cfg_kernel_i = 3'(k - 1); cfg_stride_i = 3'(s - 1); cfg_pad_i = 3'(p);
        cfg_height_i = 8'(h); cfg_width_i = 8'(w); cfg_base_i = base;
        cfg_valid_i = 1'b1;
        valid_seen = 0; stalls = 0; job_hs = 0;
        @(posedge clk);
        #1 cfg_valid_i = 1'b0;
        @(negedge clk);
        chk({name, "_busy_ready"}, {62'd0, busy_o, cfg_ready_o}, 64'b10);
    endtask

    task automatic run_job(input logic [1:0] t, input int k, input int s, input int p,
                           input int h, input int w, input logic [15:0] base,
                           input bit exp_err, input string name);
        int n, acc;
        start_job(t, k, s, p, h, w, base, name);
        acc = cyc - 1;
        n = 0;
        while (!done_o && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!done_o) begin
            chk({name, "_done_timeout"}, 64'd0, 64'd1);
        end else begin
            chk({name, "_err"}, 64'(err_o), 64'(exp_err));
            chk({name, "_valid_in_done"}, 64'(elem_valid_o), 64'd0);
            if (exp_err) begin
                chk({name, "_done_lat"}, 64'(cyc - acc), 64'd2);
                chk({name, "_valid_seen"}, 64'(valid_seen), 64'd0);
            end else begin
                chk({name, "_done_after_last"}, 64'(cyc - last_hs_cyc), 64'd1);
                chk({name, "_leftover"}, 64'(exp_q.size()), 64'd0);
            end
`ifdef NPU_POOL_SEQ_PERF_EN
            chk({name, "_stall_cnt"}, 64'(stall_cnt_o), 64'(stalls));
`endif
        end
        @(negedge clk);
        chk({name, "_post_done"}, {62'd0, done_o, busy_o}, 64'd0);
    endtask

    // Monitor: pops one expectation per handshake, checks hold during stalls.
    initial begin
        logic [34:0] saved, cur;
        bit prev_stall;
        exp_t e;
        prev_stall = 0;
        saved = '0;
        forever begin
            @(negedge clk);
            cur = {elem_addr_o, elem_pad_o, elem_first_o, elem_last_o, out_row_o, out_col_o};
            if (!rst_ni) begin
                prev_stall = 0;
            end else begin
                if (elem_valid_o) valid_seen = 1;
                if (prev_stall) chk("stall_hold", 64'(cur), 64'(saved));
                if (elem_valid_o && elem_ready_i) begin
                    if (exp_q.size() == 0) begin
                        chk("elem_unexpected", 64'(cur), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("elem", 64'(cur), 64'({e.addr, e.pad, e.first, e.last, e.row, e.col}));
                    end
                    job_hs++;
                    last_hs_cyc = cyc;
                    prev_stall = 0;
                end else if (elem_valid_o) begin
                    stalls++;
                    saved = cur;
                    prev_stall = 1;
                end else begin
                    prev_stall = 0;
                end
            end
        end
    end

    initial begin
        elem_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1 elem_ready_i = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        int n, bad;
        rst_ni = 1'b0; cfg_valid_i = 1'b0; cfg_type_i = '0; cfg_kernel_i = '0; cfg_stride_i = '0;
        cfg_pad_i = '0; cfg_height_i = '0; cfg_width_i = '0; cfg_base_i = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({cfg_ready_o, elem_valid_o, elem_addr_o, elem_pad_o, elem_first_o,
                                  elem_last_o, out_row_o, out_col_o, busy_o, done_o, err_o}), 64'd0);
        rst_ni = 1'b1;

        push_job1();
        run_job(2'b00, 2, 2, 0, 4, 4, 16'h0100, 1'b0, "k2s2");

        push_model(3, 3, 3, 1, 1, 32'h20, 1'b0);
        run_job(2'b00, 3, 1, 1, 3, 3, 16'h0020, 1'b0, "k3p1");

        for (int i = 0; i < 6; i++) push_e(16'(i), 1'b0, i == 0, i == 5, 8'd0, 8'd0);
        run_job(2'b10, 1, 1, 0, 2, 3, 16'h0000, 1'b0, "global");

        push_e(16'hFFFE, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
        push_e(16'hFFFF, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        push_e(16'h0000, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        push_e(16'h0001, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0);
        run_job(2'b01, 2, 1, 0, 2, 2, 16'hFFFE, 1'b0, "addr_wrap");

        run_job(2'b00, 4, 1, 0, 2, 8, 16'h0000, 1'b1, "rej_kernel");
        run_job(2'b11, 2, 1, 0, 4, 4, 16'h0000, 1'b1, "rej_type");

        rand_rdy = 1;
        push_job1();
        run_job(2'b00, 2, 2, 0, 4, 4, 16'h0100, 1'b0, "rand_ready");
        rand_rdy = 0;

        push_job1();
        start_job(2'b00, 2, 2, 0, 4, 4, 16'h0100, "abort");
        n = 0;
        while (job_hs < 4 && n < 100) begin
            @(posedge clk);
            #2 n++;
        end
        chk("abort_reached_elem5", 64'(job_hs), 64'd4);
        rst_ni = 1'b0;
        #1;
        chk("abort_outputs", 64'({cfg_ready_o, elem_valid_o, elem_addr_o, elem_pad_o, elem_first_o,
                                  elem_last_o, out_row_o, out_col_o, busy_o, done_o, err_o}), 64'd0);
        exp_q.delete();
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (done_o) bad++;
        end
        rst_ni = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done_o || elem_valid_o) bad++;
        end
        chk("abort_no_done", 64'(bad), 64'd0);

        push_job1();
        run_job(2'b00, 2, 2, 0, 4, 4, 16'h0100, 1'b0, "after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/npu_pool_seq.md
Name: npu_pool_seq

Overview:
Job sequencer for the NPU cluster pooling datapath.
- Accepts one pooling job descriptor: feature-map size, kernel, stride, padding, pool type, base address.
- Walks every output window position in raster order, and every element inside each window.
- Emits one element request per handshake: feature-buffer address, pad flag, window first/last markers.
- Sits between the cluster job dispatcher (config side) and the feature-buffer read port / pooling datapath (element side).

Parameters:
DIM_W, 8, width of feature-map height/width fields (max map dimension 2^DIM_W-1)
ADDR_W, 16, feature-buffer word address width

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset
cfg_valid_i  in  1  job descriptor valid
cfg_ready_o  out  1  sequencer can accept a job
cfg_type_i  in  2  00 max, 01 avg, 10 global, 11 reserved
cfg_kernel_i  in  3  kernel size minus 1 (K = 1..8)
cfg_stride_i  in  3  stride minus 1 (S = 1..8)
cfg_pad_i  in  3  padding P = 0..7
cfg_height_i  in  DIM_W  map height H, 1..2^DIM_W-1
cfg_width_i  in  DIM_W  map width W, 1..2^DIM_W-1
cfg_base_i  in  ADDR_W  address of element (0,0)
elem_valid_o  out  1  element request valid
elem_ready_i  in  1  datapath accepts element
elem_addr_o  out  ADDR_W  element address
elem_pad_o  out  1  element lies in padding; addr forced 0
elem_first_o  out  1  first element of a window
elem_last_o  out  1  last element of a window
out_row_o  out  DIM_W  output row of current window
out_col_o  out  DIM_W  output column of current window
busy_o  out  1  job in progress
done_o  out  1  one-cycle job completion pulse
err_o  out  1  one-cycle pulse, job rejected (same cycle as done_o)

Behaviour:
- Reset is rst_ni, asynchronous, active-low; clock is clk_i. All outputs are registered.
- Reset values: cfg_ready_o=0, busy_o=0, done_o=0, err_o=0, elem_valid_o=0, and every other output 0.
- FSM states: IDLE, CHECK, RUN, DONE. Reset state is IDLE.
- IDLE:
  - cfg_ready_o=1.
  - When cfg_valid_i&&cfg_ready_o, latch all cfg fields, go to CHECK, busy_o=1.
- CHECK (one cycle): the job is rejected if any of these holds:
  - type==11;
  - non-global and K > H+2P;
  - non-global and K > W+2P.
  - On rejection: go to DONE with err_o.
  - Otherwise: load the counters and go to RUN.
- Global type:
  - kernel = H x W, stride = 1, pad = 0.
  - Exactly one window at (0,0).
  - Kernel counters are DIM_W wide.
- Window origin: (r0,c0) starts at (-P,-P), held as signed DIM_W+2-bit values.
- Iteration order, innermost first: kc, kr, then output col, then output row.
  - Column origin advances by S while c0+S+K <= W+P; otherwise wrap to -P and advance the row.
  - The job ends when r0+S+K > H+P after the last column of the last row.
  - No divider is used.
- Element coordinates: r=r0+kr, c=c0+kc.
  - Padding when r<0, r>=H, c<0 or c>=W: elem_pad_o=1, addr=0.
  - Otherwise addr = base + r*W + c, modulo 2^ADDR_W.
- Markers:
  - elem_first_o=1 when kr=kc=0.
  - elem_last_o=1 when kr=kc=K-1 (global: H-1, W-1).
- RUN:
  - elem_valid_o=1; the counters advance only on elem_valid_o&&elem_ready_i.
  - While valid&&!ready, all elem_*/out_* outputs hold stable.
  - No bubbles between accepted elements: the next element is valid in the cycle after the handshake.
  - The handshake on the last element of the last window goes to DONE; elem_valid_o drops in the next cycle.
- DONE (one cycle): done_o=1, busy_o=0 next cycle, return to IDLE. Earliest next acceptance is the cycle after DONE.
- cfg_valid_i is ignored while not in IDLE.
- Reset mid-RUN aborts the job with no done_o.

Optional Feature:
NPU_POOL_SEQ_PERF_EN
- Defined: adds output stall_cnt_o [31:0].
  - Counts cycles with elem_valid_o&&!elem_ready_i.
  - Cleared on job acceptance; saturates at 2^32-1; holds after done.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package npu_pool_pkg holds:
  - pool_type_e (MAX=00, AVG=01, GLOBAL=10, RSVD=11);
  - pool_seq_state_e;
  - pool_cfg_t struct (type, kernel, stride, pad, height, width, base);
  - encoding constants K_ENC_OFFSET=1, S_ENC_OFFSET=1.
- One natural sub-module: npu_pool_addr_gen.
  - Combinational plus one register stage.
  - Computes the pad flag and address from r0, c0, kr, kc, H, W, base.

Test Plan:
- H=W=4, K=2, S=2, P=0, base=0x100, ready=1:
  - 16 elements, 4 windows.
  - Window (0,0) addrs 0x100, 0x101, 0x104, 0x105; window (0,1) addrs 0x102, 0x103, 0x106, 0x107.
  - first/last on elements 1/4 of each window; done_o 1 cycle after the 16th handshake; err_o=0.
- H=W=3, K=3, S=1, P=1:
  - 9 windows, 81 elements.
  - Window (0,0): elements kr=0 and kc=0 have pad=1; element (1,1) addr=base+0.
  - Window (2,2): element (2,2) pad=1.
- H=2, W=3, type=10, base=0:
  - 6 elements, addrs 0..5; first on addr 0, last on addr 5; out_row=out_col=0 throughout.
- H=2, W=8, K=4, P=0, type=00:
  - err_o and done_o pulse together 2 cycles after acceptance; elem_valid_o never asserts.
  - Repeat with type=11: same result.
- Random elem_ready_i (50%) on the first job:
  - Identical element sequence; outputs stable during stalls.
  - With NPU_POOL_SEQ_PERF_EN, stall_cnt_o equals the stall cycles counted by the bench.
- Assert rst_ni low at the 5th element of a job:
  - All outputs 0 immediately; no done_o.
  - The next job after reset runs from window (0,0).
